uart_rx_ext: RTL and testbench
==============================

# uart_rx_ext

Parametrised UART receiver, successor to the basic 8N1 receiver. Adds configurable stop-bit count, optional parity, 3-sample majority voting, false-start rejection and per-word error status (framing, parity, overrun). Sits between the pad-side serial input and any valid/ready consumer, such as a FIFO or command decoder, in the same clock domain.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- BAUD_RATE, 115200, line rate in bit/s
- CLK_FREQ, 100_000_000, clk frequency in Hz; PULSE_WIDTH = CLK_FREQ / BAUD_RATE (integer division), must be >= 8
- STOP_BITS, 1, stop bits checked per frame (1 or 2)
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; only meaningful with UART_RX_PARITY_EN
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- uart_in  input  1  serial line, idle high, asynchronous to clk
- ready  input  1  consumer can accept a word
- data  output  DATA_WIDTH  received word, LSB = first bit on the line
- valid  output  1  data and the status flags are valid
- frame_err  output  1  status for the current word: a stop bit was sampled 0
- parity_err  output  1  status for the current word: parity mismatch
- overrun_err  output  1  one-cycle pulse: a completed frame was dropped

## Operation
- uart_in passes through a 2-flop synchroniser. All logic uses the synchronised value `rx_s`.
- HALF = PULSE_WIDTH/2. Each bit is decided by a majority of 3 samples taken at bit-relative cycles HALF-1, HALF and HALF+1.
- States:
  - IDLE: waits for a 1→0 transition on rx_s, then clears the bit counter and goes to START.
  - START: if the start-bit majority is 1, the start is false and the FSM returns to IDLE. Otherwise it goes to DATA.
  - DATA: shifts in DATA_WIDTH bits, LSB first.
  - PARITY: present only with UART_RX_PARITY_EN.
  - STOP: checks STOP_BITS bits.
  - BREAK: entered after a framing error. Waits until rx_s has been 1 for one full PULSE_WIDTH, then goes to IDLE.
- Bit counter: cycle counter width $clog2(PULSE_WIDTH). It wraps from PULSE_WIDTH-1 to 0 and advances the bit index on each wrap.
- Word commit happens at the majority decision of the last stop bit, or at the first stop bit that decides 0:
  - If valid=0, or valid=1 with ready=1 in the same cycle: data, frame_err and parity_err are loaded and valid=1 on the next cycle.
  - If valid=1 and ready=0: the new word is dropped, the held word and flags are kept, and overrun_err pulses for 1 cycle.
- After a good last stop bit, the FSM enters IDLE right away. It does not wait for end-of-bit, so back-to-back frames are accepted.
- After a framing error, the word is still committed with frame_err=1 and the FSM goes to BREAK.
- Handshake: valid stays high until it is sampled together with ready. It clears on the cycle after valid&&ready unless a new commit happens in that same cycle.

## Timing
- Reset values: data=0, valid=0, frame_err=0, parity_err=0, overrun_err=0, FSM in IDLE, both synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No word is committed and no error is flagged.
- Latency from the start edge at uart_in to the valid rise is 2 + (1 + DATA_WIDTH + P + STOP_BITS - 1) × PULSE_WIDTH + HALF + 2 cycles ±1, where P = 1 with parity and 0 otherwise.
- Glitch rejection: a low pulse shorter than HALF-1 cycles gives no output.
- Single-sample noise inside any bit is masked by the majority vote.
- frame_err and parity_err change only on commit. overrun_err never coincides with a valid rise.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: one parity bit follows the data bits. parity_err = (XOR of data bits ^ parity bit) != PARITY_ODD.
  - Undefined: no parity state exists, frame length is 1+DATA_WIDTH+STOP_BITS, and parity_err is tied to 0.

## Test plan
- Defaults (PULSE_WIDTH=868), 8N1, send 0x00..0xFF with ready=1 → every data matches and no error flags are set.
- Send 0xA5 then 0x3C back-to-back with ready held 0 → first word 0xA5 held, overrun_err pulses once, and data stays 0xA5 after ready rises.
- Stop bit forced 0 on 0x55 → data=0x55 with frame_err=1. A frame started during the 868-cycle break-idle period is ignored; the next valid frame is received normally.
- UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 → parity_err=1. Repeat with parity bit 1 → parity_err=0.
- 300-cycle low glitch on the idle line → no valid. A 1-cycle inverted spike at the centre of bit 3 of 0x81 → data=0x81.
- STOP_BITS=2 with the second stop bit 0 → frame_err=1. Assert rstn low mid-DATA → all outputs return to 0 and the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ext_if.sv
// Word-side handshake of uart_rx_ext: received word, status flags and consumer ready.
interface uart_rx_ext_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  frame_err;
  logic                  parity_err;
  logic                  overrun_err;

  modport master (output data, valid, frame_err, parity_err, overrun_err, input ready);
  modport slave  (input data, valid, frame_err, parity_err, overrun_err, output ready);
endinterface

// File: rtl/uart_rx_ext.sv
// UART receiver: 2-flop sync, 3-sample majority vote, 1/2 stop bits, per-word error status.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_ext #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          uart_in,
  uart_rx_ext_if.master bus
);
  localparam int unsigned PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF        = PULSE_WIDTH / 2;
  localparam int unsigned CW          = $clog2(PULSE_WIDTH);
  localparam int unsigned IW          = 4;

  if (PULSE_WIDTH < 8 || DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_ext: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  rx_s, rx_prev_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         bit_idx_q;
  logic                  s0_q, s1_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  fall_c, decide_c, wrap_c, maj_c, last_data_c, last_stop_c;
  logic                  commit_c, frame_bad_c, par_err_c;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, frame_err_q, parity_err_q, overrun_q;

  // Synchroniser idles high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], uart_in};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s        = sync_q[1];
  assign fall_c      = rx_prev_q & ~rx_s;
  assign decide_c    = (cnt_q == CW'(HALF + 1));
  assign wrap_c      = (cnt_q == CW'(PULSE_WIDTH - 1));
  assign maj_c       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign last_data_c = (bit_idx_q == IW'(DATA_WIDTH - 1));
  assign last_stop_c = (bit_idx_q == IW'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; commit fires on the first bad stop bit or the last good one
  always_comb begin
    state_d     = state_q;
    commit_c    = 1'b0;
    frame_bad_c = 1'b0;
    case (state_q)
      S_IDLE:  if (fall_c) state_d = S_START;
      S_START: begin
        if (decide_c && maj_c) state_d = S_IDLE;
        else if (wrap_c)       state_d = S_DATA;
      end
      S_DATA:  if (wrap_c && last_data_c) state_d = S_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (wrap_c) state_d = S_STOP;
`endif
      S_STOP: begin
        if (decide_c) begin
          if (!maj_c) begin
            commit_c    = 1'b1;
            frame_bad_c = 1'b1;
            state_d     = S_BREAK;
          end else if (last_stop_c) begin
            commit_c = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_BREAK: if (rx_s && wrap_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing, sample capture and data shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
        end
        S_BREAK: cnt_q <= (!rx_s || wrap_c) ? '0 : cnt_q + CW'(1);
        default: begin
          cnt_q <= (wrap_c || state_d == S_BREAK) ? '0 : cnt_q + CW'(1);
          if (wrap_c) bit_idx_q <= (state_d != state_q) ? '0 : bit_idx_q + IW'(1);
          if (cnt_q == CW'(HALF - 1)) s0_q <= rx_s;
          if (cnt_q == CW'(HALF))     s1_q <= rx_s;
          if (decide_c && state_q == S_DATA) shreg_q <= {maj_c, shreg_q[DATA_WIDTH-1:1]};
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                par_bit_q <= 1'b0;
    else if (decide_c && state_q == S_PARITY) par_bit_q <= maj_c;
  end

  assign par_err_c = ((^shreg_q) ^ par_bit_q) != 1'(PARITY_ODD);
`else
  assign par_err_c = 1'b0;
`endif

  // Output word holding register; a commit while the held word is unaccepted is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (commit_c) begin
        if (!valid_q || bus.ready) begin
          data_q       <= shreg_q;
          frame_err_q  <= frame_bad_c;
          parity_err_q <= par_err_c;
          valid_q      <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: a 1-stop and a 2-stop receiver on separate serial lines.
module tb_uart_rx_ext;
  localparam int unsigned BAUD = 115200;
  localparam int unsigned CLKF = BAUD * 16;
  localparam int          PW   = 16;
  localparam int          HALF = PW / 2;
  localparam logic        PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic line1 = 1'b1;
  logic line2 = 1'b1;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_pass  = 0;
  int   n_total = 0;
  int   ovr1    = 0;
  int   ovr2    = 0;
  bit   rand_rdy = 1'b0;
  logic prev_v1 = 1'b0;
  logic prev_v2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ext_if #(.DATA_WIDTH(8)) bus1 ();
  uart_rx_ext_if #(.DATA_WIDTH(8)) bus2 ();

  uart_rx_ext #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .STOP_BITS(1), .PARITY_ODD(0))
    dut1 (.clk(clk), .rstn(rstn), .uart_in(line1), .bus(bus1));
  uart_rx_ext #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .STOP_BITS(2), .PARITY_ODD(0))
    dut2 (.clk(clk), .rstn(rstn), .uart_in(line2), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  task automatic set_line(input int which, input logic b);
    if (which == 0) line1 = b;
    else            line2 = b;
  endtask

  // One bit period; optional one-cycle inversion at the bit centre
  task automatic drive_bit(input int which, input logic b, input bit spike);
    for (int c = 0; c < PW; c++) begin
      set_line(which, (spike && c == HALF) ? ~b : b);
      @(posedge clk);
    end
  endtask

  // sp[i] = value of the i-th stop bit sent; spike_at = frame bit index (0 = start) or -1
  task automatic send_frame(input int which, input logic [7:0] d, input logic [1:0] sp,
                            input logic pbit, input int spike_at, input int gap, input bit push);
    exp_t e;
    int   nstop;
    nstop = (which == 0) ? 1 : 2;
    e.d   = d;
    e.fe  = (nstop == 1) ? ~sp[0] : ~(sp[0] & sp[1]);
    e.pe  = PAR_EN && (((^d) ^ pbit) != PODD);
    if (push) begin
      if (which == 0) q1.push_back(e);
      else            q2.push_back(e);
    end
    drive_bit(which, 1'b0, spike_at == 0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], spike_at == i + 1);
    if (PAR_EN) drive_bit(which, pbit, 1'b0);
    for (int i = 0; i < nstop; i++) drive_bit(which, sp[i], 1'b0);
    set_line(which, 1'b1);
    repeat (gap) @(posedge clk);
  endtask

  // Monitors: pop and compare on every accepted word
  always @(negedge clk) begin
    if (bus1.valid && bus1.ready) begin
      check("dut1_word_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("dut1_data", 32'(bus1.data), 32'(e1.d));
        check("dut1_frame_err", 32'(bus1.frame_err), 32'(e1.fe));
        check("dut1_parity_err", 32'(bus1.parity_err), 32'(e1.pe));
      end
    end
    if (bus1.overrun_err) begin
      ovr1++;
      check("dut1_ovr_with_valid_rise", 32'(bus1.valid && !prev_v1), 32'd0);
    end
    prev_v1 <= bus1.valid;
  end

  always @(negedge clk) begin
    if (bus2.valid && bus2.ready) begin
      check("dut2_word_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        check("dut2_data", 32'(bus2.data), 32'(e2.d));
        check("dut2_frame_err", 32'(bus2.frame_err), 32'(e2.fe));
        check("dut2_parity_err", 32'(bus2.parity_err), 32'(e2.pe));
      end
    end
    if (bus2.overrun_err) ovr2++;
    prev_v2 <= bus2.valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus1.ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    int         base;
    bus1.ready = 1'b1;
    bus2.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus1.valid), 32'd0);
    check("rst_data", 32'(bus1.data), 32'd0);
    check("rst_frame_err", 32'(bus1.frame_err), 32'd0);
    check("rst_parity_err", 32'(bus1.parity_err), 32'd0);
    check("rst_overrun_err", 32'(bus1.overrun_err), 32'd0);
    rstn = 1'b1;
    repeat (2 * PW) @(posedge clk);

    // Random words, random gaps (including back-to-back), random ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      send_frame(0, d, 2'b11, p, -1, $urandom_range(0, 3), 1'b1);
    end
    // Single-cycle spike in the centre of data bit 3
    send_frame(0, 8'h81, 2'b11, good_par(8'h81), 4, 2 * PW, 1'b1);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 bus1.ready = 1'b1;
    repeat (2 * PW) @(posedge clk);

    // Overrun: second word dropped while the first is held
    #1 bus1.ready = 1'b0;
    base = ovr1;
    send_frame(0, 8'hA5, 2'b11, good_par(8'hA5), -1, 0, 1'b1);
    send_frame(0, 8'h3C, 2'b11, good_par(8'h3C), -1, 2 * PW, 1'b0);
    #1;
    check("ovr_hold_valid", 32'(bus1.valid), 32'd1);
    check("ovr_hold_data", 32'(bus1.data), 32'hA5);
    check("ovr_pulse_count", 32'(ovr1 - base), 32'd1);
    bus1.ready = 1'b1;
    repeat (PW) @(posedge clk);
    #1;
    check("ovr_after_ready_data", 32'(bus1.data), 32'hA5);
    check("ovr_after_ready_valid", 32'(bus1.valid), 32'd0);

    // Framing error, a frame inside the break-idle period, then a clean frame
    send_frame(0, 8'h55, 2'b10, good_par(8'h55), -1, 4, 1'b1);
    send_frame(0, 8'h00, 2'b11, good_par(8'h00), -1, 3 * PW, 1'b0);
    send_frame(0, 8'h5A, 2'b11, good_par(8'h5A), -1, 2 * PW, 1'b1);

    // Explicit parity bits on 0x07
    send_frame(0, 8'h07, 2'b11, 1'b0, -1, 2 * PW, 1'b1);
    send_frame(0, 8'h07, 2'b11, 1'b1, -1, 2 * PW, 1'b1);

    // Short low glitch on the idle line
    line1 = 1'b0;
    repeat (HALF - 3) @(posedge clk);
    line1 = 1'b1;
    repeat (3 * PW) @(posedge clk);
    #1 check("glitch_no_valid", 32'(bus1.valid), 32'd0);

    // Reset in the middle of the data bits
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    repeat (HALF) @(posedge clk);
    #1;
    rstn  = 1'b0;
    line1 = 1'b1;
    #1;
    check("midrst_valid", 32'(bus1.valid), 32'd0);
    check("midrst_data", 32'(bus1.data), 32'd0);
    check("midrst_frame_err", 32'(bus1.frame_err), 32'd0);
    check("midrst_parity_err", 32'(bus1.parity_err), 32'd0);
    check("midrst_overrun_err", 32'(bus1.overrun_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2 * PW) @(posedge clk);
    send_frame(0, 8'h3C, 2'b11, good_par(8'h3C), -1, 2 * PW, 1'b1);

    // Two-stop-bit receiver: good frame, bad second stop, recovery frame
    send_frame(1, 8'h96, 2'b11, good_par(8'h96), -1, 2 * PW, 1'b1);
    send_frame(1, 8'h4B, 2'b01, good_par(8'h4B), -1, 3 * PW, 1'b1);
    send_frame(1, 8'hC3, 2'b11, good_par(8'hC3), -1, 2 * PW, 1'b1);

    repeat (2 * PW) @(posedge clk);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    check("dut2_queue_drained", 32'(q2.size()), 32'd0);
    check("dut1_overrun_total", 32'(ovr1), 32'd1);
    check("dut2_overrun_total", 32'(ovr2), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
